// File: rtl/rice_pkg.sv
// Shared definitions for the Rice stream encoder.
//
// Contents:
//   DEFAULT_SAMPLE_WIDTH : default signed residual width W
//   DEFAULT_PARAM_WIDTH  : default Rice-parameter port width P
//   DEFAULT_ESC_LIMIT    : default largest quotient coded in Rice form
//   ZZ_WIDTH             : working width of the zigzag helper
//   zigzag()             : signed-to-unsigned interleave (0,-1,1,-2,... -> 0,1,2,3,...)
package rice_pkg;

   localparam int DEFAULT_SAMPLE_WIDTH = 16;
   localparam int DEFAULT_PARAM_WIDTH  = 5;
   localparam int DEFAULT_ESC_LIMIT    = 32;
   localparam int ZZ_WIDTH             = 64;

   // The helper works on a wide sign-extended value so it can serve any sample
   // width below ZZ_WIDTH; the caller keeps the low W bits. The low W bits of the
   // wide result equal the W-bit zigzag because the XOR mask is the sign bit
   // replicated, and that sign bit is the same in both widths.
   function automatic logic [ZZ_WIDTH-1:0] zigzag(input logic [ZZ_WIDTH-1:0] s_ext);
      return (s_ext << 1) ^ {ZZ_WIDTH{s_ext[ZZ_WIDTH-1]}};
   endfunction

endpackage

// File: rtl/rice_partition_accumulator.sv
// Running bit total for one Rice partition.
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   beat_valid  : an encoded beat is on the output
//   beat_ready  : downstream accepts that beat this cycle
//   beat_last   : the beat closes the partition
//   beat_bits   : code length of the beat
//   total       : partition total including the beat currently shown
module rice_partition_accumulator #(
   parameter int BITS_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  beat_valid,
   input  logic                  beat_ready,
   input  logic                  beat_last,
   input  logic [BITS_WIDTH-1:0] beat_bits,
   output logic [31:0]           total
);

   logic [31:0] acc;
   logic [32:0] sum;
   logic [31:0] saturated;

   // The reported total already counts the beat on display, so a one-beat
   // partition shows its own length. The extra carry bit drives saturation.
   always_comb begin
      sum       = {1'b0, acc} + 33'(beat_bits);
      saturated = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      total     = beat_valid ? saturated : acc;
   end

   // Commit only on an accepted beat; the closing beat restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (beat_valid && beat_ready) begin
         acc <= beat_last ? 32'd0 : saturated;
      end
   end

endmodule

// File: rtl/rice_stream_encoder.sv
// Three-stage streaming Rice encoder: register -> zigzag -> encode.
//
// Ports:
//   iClock, iReset_n        : clock and asynchronous active-low reset
//   iValid/oReady           : input handshake
//   iSample, iRiceParam     : signed residual and its Rice parameter k
//   iLast                   : sample closes the partition
//   oValid/iReady           : output handshake
//   oMSB                    : unary quotient (0 when escaped)
//   oLSB                    : (1<<k)|r, or the raw zigzag value when escaped
//   oBitsUsed               : code length in bits
//   oEscape, oLast          : escape flag, partition end flag
//   oPartitionBits          : running partition total, valid with oValid&oLast
module rice_stream_encoder
   import rice_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
   parameter int PARAM_WIDTH  = DEFAULT_PARAM_WIDTH,
   parameter int ESC_LIMIT    = DEFAULT_ESC_LIMIT
) (
   input  logic                    iClock,
   input  logic                    iReset_n,
   input  logic                    iValid,
   output logic                    oReady,
   input  logic [SAMPLE_WIDTH-1:0] iSample,
   input  logic [PARAM_WIDTH-1:0]  iRiceParam,
   input  logic                    iLast,
   output logic                    oValid,
   input  logic                    iReady,
   output logic [SAMPLE_WIDTH-1:0] oMSB,
   output logic [SAMPLE_WIDTH-1:0] oLSB,
   output logic [SAMPLE_WIDTH:0]   oBitsUsed,
   output logic                    oEscape,
   output logic                    oLast,
   output logic [31:0]             oPartitionBits
);

   logic                    enable;
   logic [PARAM_WIDTH-1:0]  k_clamped;

   logic                    s1_valid, s1_last;
   logic [SAMPLE_WIDTH-1:0] s1_sample;
   logic [PARAM_WIDTH-1:0]  s1_k;

   logic                    s2_valid, s2_last;
   logic [SAMPLE_WIDTH-1:0] s2_u;
   logic [PARAM_WIDTH-1:0]  s2_k;

   logic [ZZ_WIDTH-1:0]     s1_ext;
   logic [SAMPLE_WIDTH-1:0] u_next;

   logic [SAMPLE_WIDTH-1:0] quotient, remainder, mask;
   logic [SAMPLE_WIDTH-1:0] enc_msb, enc_lsb;
   logic [SAMPLE_WIDTH:0]   enc_bits;
   logic                    enc_escape;

   // One enable moves the whole pipeline; the reset term keeps the input
   // closed while reset is held.
   assign enable = !oValid || iReady;
   assign oReady = iReset_n && enable;

   // k beyond the sample width would shift everything out, so it is capped.
   always_comb begin
      k_clamped = iRiceParam;
      if (32'(iRiceParam) >= SAMPLE_WIDTH) begin
         k_clamped = PARAM_WIDTH'(SAMPLE_WIDTH - 1);
      end
   end

   // Sign-extend to the helper width before zigzagging.
   always_comb begin
      s1_ext = {{(ZZ_WIDTH-SAMPLE_WIDTH){s1_sample[SAMPLE_WIDTH-1]}}, s1_sample};
      u_next = SAMPLE_WIDTH'(zigzag(s1_ext));
   end

   // Rice split of u into quotient and remainder; large quotients fall back to
   // a fixed-length escape carrying u verbatim.
   always_comb begin
      quotient   = s2_u >> s2_k;
      mask       = (SAMPLE_WIDTH'(1) << s2_k) - SAMPLE_WIDTH'(1);
      remainder  = s2_u & mask;
      enc_escape = 1'b0;
      enc_msb    = quotient;
      enc_lsb    = (SAMPLE_WIDTH'(1) << s2_k) | remainder;
      enc_bits   = (SAMPLE_WIDTH+1)'(quotient) + (SAMPLE_WIDTH+1)'(s2_k)
                   + (SAMPLE_WIDTH+1)'(1);
      if (32'(quotient) > ESC_LIMIT) begin
         enc_escape = 1'b1;
         enc_msb    = '0;
         enc_lsb    = s2_u;
         enc_bits   = (SAMPLE_WIDTH+1)'(ESC_LIMIT + 1 + SAMPLE_WIDTH);
      end
   end

   // Pipeline registers. Data follows its valid bit through every stage,
   // including k, so bubbles just carry valid=0 forward.
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_sample <= '0;
         s1_k      <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_u      <= '0;
         s2_k      <= '0;
         oValid    <= 1'b0;
         oMSB      <= '0;
         oLSB      <= '0;
         oBitsUsed <= '0;
         oEscape   <= 1'b0;
         oLast     <= 1'b0;
      end else if (enable) begin
         s1_valid  <= iValid;
         s1_last   <= iLast;
         s1_sample <= iSample;
         s1_k      <= k_clamped;
         s2_valid  <= s1_valid;
         s2_last   <= s1_last;
         s2_u      <= u_next;
         s2_k      <= s1_k;
         oValid    <= s2_valid;
         oMSB      <= enc_msb;
         oLSB      <= enc_lsb;
         oBitsUsed <= enc_bits;
         oEscape   <= enc_escape;
         oLast     <= s2_last;
      end
   end

   rice_partition_accumulator #(
      .BITS_WIDTH(SAMPLE_WIDTH + 1)
   ) u_accumulator (
      .clk        (iClock),
      .rst_n      (iReset_n),
      .beat_valid (oValid),
      .beat_ready (iReady),
      .beat_last  (oLast),
      .beat_bits  (oBitsUsed),
      .total      (oPartitionBits)
   );

endmodule

// File: doc/rice_stream_encoder.md
RICE_STREAM_ENCODER -- requirements
Module: rice_stream_encoder

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, meaning signed residual width W.
REQ-002 SHALL have parameter PARAM_WIDTH, default 5, meaning Rice-parameter port width P.
REQ-003 SHALL have parameter ESC_LIMIT, default 32, meaning largest quotient coded in Rice form before escape.
REQ-004 SHALL have port iClock, input, 1, meaning the single clock for all state.
REQ-005 SHALL have port iReset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port iValid, input, 1, meaning the input beat is present.
REQ-007 SHALL have port oReady, output, 1, meaning the encoder accepts the input beat this cycle.
REQ-008 SHALL have port iSample, input, W, meaning the signed residual.
REQ-009 SHALL have port iRiceParam, input, P, meaning the Rice parameter k for this sample.
REQ-010 SHALL have port iLast, input, 1, meaning the last sample of the partition.
REQ-011 SHALL have port oValid, output, 1, meaning the output beat is present.
REQ-012 SHALL have port iReady, input, 1, meaning downstream accepts the output beat.
REQ-013 SHALL have port oMSB, output, W, meaning the unary quotient q (0 when escaped).
REQ-014 SHALL have port oLSB, output, W, meaning (1<<k)|r, or the raw zigzag value u when escaped.
REQ-015 SHALL have port oBitsUsed, output, W+1, meaning the code length in bits.
REQ-016 SHALL have port oEscape, output, 1, meaning the beat is escape-coded.
REQ-017 SHALL have port oLast, output, 1, meaning iLast delayed with the beat.
REQ-018 SHALL have port oPartitionBits, output, 32, meaning the partition bit total, valid when oValid&oLast.

Function
REQ-019 A transfer SHALL occur on a cycle with iValid&oReady at input and oValid&iReady at output.
REQ-020 The block SHALL be a 3-stage pipeline (register, zigzag, encode) with global enable = !oValid | iReady.
REQ-021 oReady SHALL equal that enable, so a full pipeline accepts a new beat in the same cycle the output drains.
REQ-022 Latency SHALL be 3 cycles from input transfer to oValid when unstalled; throughput SHALL be 1 beat per cycle.
REQ-023 While oValid&!iReady, every output SHALL hold stable and no stage SHALL advance.
REQ-024 Zigzag SHALL give u = (s<<1) XOR (W copies of the sign bit), in W bits; -2^(W-1) maps to 2^W-1.
REQ-025 k SHALL be clamped to W-1 when iRiceParam >= W; k travels with its sample through every stage.
REQ-026 q = u>>k, r = u & ((1<<k)-1); with k=0, oLSB=1 and oBitsUsed=q+1.
REQ-027 If q <= ESC_LIMIT then oEscape=0, oMSB=q, oLSB=(1<<k)|r, and oBitsUsed=q+1+k.
REQ-028 If q > ESC_LIMIT then oEscape=1, oMSB=0, oLSB=u, and oBitsUsed=ESC_LIMIT+1+W.
REQ-029 The accumulator SHALL add oBitsUsed on each output transfer; oPartitionBits SHALL include the current beat.
REQ-030 The accumulator SHALL clear after the oLast transfer, and SHALL saturate at 2^32-1.
REQ-031 A partition of one sample (iLast on the first beat) SHALL report that beat's oBitsUsed alone.
REQ-032 Bubbles (iValid=0) SHALL propagate as oValid=0 without altering the accumulator.

Reset
REQ-033 Asserting iReset_n=0 SHALL clear all pipeline valid bits, data registers and the accumulator asynchronously, at any time including mid-partition.
REQ-034 During reset, oValid=0, oReady=0, oMSB=0, oLSB=0, oBitsUsed=0, oEscape=0, oLast=0 and oPartitionBits=0.
REQ-035 oReady SHALL be 1 in the first cycle after reset release.

Structure
REQ-036 Package rice_pkg SHALL hold the default widths, the ESC_LIMIT default and the zigzag function.
REQ-037 The partition accumulator SHALL be the sub-module rice_partition_accumulator.

Verification
REQ-038 With W=16, s=-3, k=2: expect u=5, oMSB=1, oLSB=5, oBitsUsed=4, oEscape=0, oValid 3 cycles after input.
REQ-039 With s=200, k=0: expect u=400, oEscape=1, oMSB=0, oLSB=400, oBitsUsed=49.
REQ-040 With s=-32768 and k=20 (clamped to 15): expect u=65535, q=1, oLSB=65535, oBitsUsed=17.
REQ-041 Partition of samples 0, 1, -1 with k=1 and iLast on the third: expect oBitsUsed 2, 3, 2 and oPartitionBits=7 on the last beat; the next partition starts from 0.
REQ-042 Hold iReady=0 for 5 cycles under a continuous stream: expect outputs held, oReady=0 once full, and no beat lost or duplicated after release.
REQ-043 Pulse iReset_n low mid-partition: expect oValid=0 and oPartitionBits=0 immediately; the first post-reset partition totals correctly.
